cpu_bus_sync: RTL

Front-end stage between the raw Z80 pins and the CPLD's internal `cpu_bus` consumers. It synchronises the asynchronous active-low Z80 strobes into the `clk28` domain and presents them active-high with a delay-matched address/data copy. It classifies every bus cycle, emits one-cycle command strobes, and drives the `ioreq` flag that I/O port decoders use to qualify a cycle. All port, memory and DivMMC logic downstream sees only these outputs, never raw pins.

---
 rtl/cpu_bus_sync_if.sv | 50 +++++
 rtl/cpu_bus_sync.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_sync_if
// Description : Raw Z80 pin bundle in, synchronised/classified bus view out.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_bus_sync_if;
    logic        n_iorq_i;
    logic        n_mreq_i;
    logic        n_m1_i;
    logic        n_rfsh_i;
    logic        n_rd_i;
    logic        n_wr_i;
    logic [15:0] a_i;
    logic [7:0]  d_i;

    logic        iorq;
    logic        mreq;
    logic        m1;
    logic        rfsh;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic        ioreq;
    logic        io_rd_stb;
    logic        io_wr_stb;
    logic        mem_rd_stb;
    logic        mem_wr_stb;
    logic        fetch_stb;
    logic        intack_stb;
    logic [15:0] a_lat;
    logic [7:0]  d_lat;
    logic        bus_err;

    modport slave (
        input  n_iorq_i, n_mreq_i, n_m1_i, n_rfsh_i, n_rd_i, n_wr_i, a_i, d_i,
        output iorq, mreq, m1, rfsh, rd, wr, a, d, ioreq,
               io_rd_stb, io_wr_stb, mem_rd_stb, mem_wr_stb, fetch_stb, intack_stb,
               a_lat, d_lat, bus_err
    );

    modport master (
        output n_iorq_i, n_mreq_i, n_m1_i, n_rfsh_i, n_rd_i, n_wr_i, a_i, d_i,
        input  iorq, mreq, m1, rfsh, rd, wr, a, d, ioreq,
               io_rd_stb, io_wr_stb, mem_rd_stb, mem_wr_stb, fetch_stb, intack_stb,
               a_lat, d_lat, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_sync
// Description : Synchronises raw Z80 strobes/address/data into clk28, classifies
//               bus cycles and emits one-cycle command strobes plus ioreq.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input wire            clk28,
    input wire            rst_n,
    cpu_bus_sync_if.slave bus
);

    localparam logic [29:0] c_PIPE_RST = {6'h3F, 24'h0};
    localparam logic [7:0]  c_TO_LAST  = 8'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MEM  = 2'd1;
    localparam logic [1:0] c_ST_IO   = 2'd2;
    localparam logic [1:0] c_ST_INTA = 2'd3;

    localparam int c_B_IOW   = 0;
    localparam int c_B_IOR   = 1;
    localparam int c_B_MWR   = 2;
    localparam int c_B_MRD   = 3;
    localparam int c_B_FETCH = 4;
    localparam int c_B_INTA  = 5;
    localparam int c_B_ILL   = 6;

    logic [29:0] w_raw;
    logic [29:0] r_pipe [SYNC_STAGES];
    logic [29:0] w_tail;
    logic        w_iorq, w_mreq, w_m1, w_rfsh, w_rd, w_wr;
    logic [15:0] w_a;
    logic [7:0]  w_d;

    logic [6:0]  w_cond;
    logic [6:0]  r_cond_q;
    logic [6:0]  w_rise;
    logic        w_mem_ok;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;
    logic        w_timeout;
    logic [7:0]  r_cnt;

    logic        r_ioreq;
    logic [5:0]  r_stb;
    logic        r_bus_err;
    logic [15:0] r_a_lat;
    logic [7:0]  r_d_lat;

    // Strobes, address and data share one delay line so they stay aligned.
    assign w_raw = {bus.n_iorq_i, bus.n_mreq_i, bus.n_m1_i, bus.n_rfsh_i,
                    bus.n_rd_i, bus.n_wr_i, bus.a_i, bus.d_i};

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_pipe[i] <= c_PIPE_RST;
            end
        end else begin
            r_pipe[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tail = r_pipe[SYNC_STAGES-1];
    assign w_iorq = ~w_tail[29];
    assign w_mreq = ~w_tail[28];
    assign w_m1   = ~w_tail[27];
    assign w_rfsh = ~w_tail[26];
    assign w_rd   = ~w_tail[25];
    assign w_wr   = ~w_tail[24];
    assign w_a    = w_tail[23:8];
    assign w_d    = w_tail[7:0];

    // An I/O request overlapping a memory request masks all memory classes.
    assign w_mem_ok          = ~w_iorq;
    assign w_cond[c_B_IOW]   = w_iorq & w_wr & ~w_m1;
    assign w_cond[c_B_IOR]   = w_iorq & w_rd & ~w_m1;
    assign w_cond[c_B_MWR]   = w_mreq & w_wr & w_mem_ok;
    assign w_cond[c_B_MRD]   = w_mreq & w_rd & ~w_m1 & ~w_rfsh & w_mem_ok;
    assign w_cond[c_B_FETCH] = w_mreq & w_m1 & w_rd & ~w_rfsh & w_mem_ok;
    assign w_cond[c_B_INTA]  = w_iorq & w_m1;
    assign w_cond[c_B_ILL]   = w_iorq & w_mreq;
    assign w_rise            = w_cond & ~r_cond_q;

    always_comb begin
        w_state_nx = r_state;
        w_timeout  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rise[c_B_IOR] | w_rise[c_B_IOW]) begin
                    w_state_nx = c_ST_IO;
                end else if (w_rise[c_B_INTA]) begin
                    w_state_nx = c_ST_INTA;
                end else if (w_rise[c_B_FETCH] | w_rise[c_B_MRD] | w_rise[c_B_MWR]) begin
                    w_state_nx = c_ST_MEM;
                end
            end
            c_ST_IO, c_ST_INTA: begin
                if (!w_iorq) begin
                    w_state_nx = c_ST_IDLE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nx = c_ST_IDLE;
                    w_timeout  = 1'b1;
                end
            end
            c_ST_MEM: begin
                if (!w_mreq) begin
                    w_state_nx = c_ST_IDLE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nx = c_ST_IDLE;
                    w_timeout  = 1'b1;
                end
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 8'd0;
            r_cond_q  <= 7'd0;
            r_ioreq   <= 1'b0;
            r_stb     <= 6'd0;
            r_bus_err <= 1'b0;
            r_a_lat   <= 16'd0;
            r_d_lat   <= 8'd0;
        end else begin
            r_state   <= w_state_nx;
            r_cond_q  <= w_cond;
            r_ioreq   <= (w_state_nx == c_ST_IO);
            r_stb     <= w_rise[5:0];
            r_bus_err <= w_timeout | w_rise[c_B_ILL];
            // Counts cycles spent in the current busy state; zero while idle.
            if (r_state == c_ST_IDLE) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (|w_rise[5:0]) begin
                r_a_lat <= w_a;
            end
            if (w_rise[c_B_IOW] | w_rise[c_B_MWR]) begin
                r_d_lat <= w_d;
            end
        end
    end

    assign bus.iorq       = w_iorq;
    assign bus.mreq       = w_mreq;
    assign bus.m1         = w_m1;
    assign bus.rfsh       = w_rfsh;
    assign bus.rd         = w_rd;
    assign bus.wr         = w_wr;
    assign bus.a          = w_a;
    assign bus.d          = w_d;
    assign bus.ioreq      = r_ioreq;
    assign bus.io_wr_stb  = r_stb[c_B_IOW];
    assign bus.io_rd_stb  = r_stb[c_B_IOR];
    assign bus.mem_wr_stb = r_stb[c_B_MWR];
    assign bus.mem_rd_stb = r_stb[c_B_MRD];
    assign bus.fetch_stb  = r_stb[c_B_FETCH];
    assign bus.intack_stb = r_stb[c_B_INTA];
    assign bus.a_lat      = r_a_lat;
    assign bus.d_lat      = r_d_lat;
    assign bus.bus_err    = r_bus_err;

endmodule
`default_nettype wire
